// File: rtl/dds_phase_to_amp.sv
// dds_phase_to_amp
// ----------------
// Back end of the DDS: takes the accumulated phase, adds a phase offset to its
// top ADDR_W bits and turns the result into an unsigned offset-binary DAC
// amplitude. The waveform is sine (read from an external synchronous
// quarter-wave ROM), triangle, sawtooth or square. A new waveform request is
// taken on the first sample after reset and then only when the phase MSB goes
// from 1 to 0, so the switch happens at a cycle boundary.
//
// Pipeline:
//   S1: truncated + offset phase, drives rom_addr
//   S2: aligned with rom_data, which arrives one clock after rom_addr
//   S3: output register
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   phase_in    accumulator phase, sampled when phase_vld=1
//   phase_vld   phase_in valid this cycle (0 inserts a bubble)
//   p_offs      phase offset added to phase_in[PHASE_W-1 -: ADDR_W]
//   wave_sel    requested waveform: 0 sine, 1 triangle, 2 sawtooth, 3 square
//   rom_addr    quarter-wave ROM address
//   rom_data    ROM magnitude, one clock after rom_addr
//   amp_out     amplitude, midscale = 2**(AMP_W-1)
//   amp_vld     amp_out updated this cycle
//   wave_cur    waveform currently applied
module dds_phase_to_amp #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 11,
  parameter int AMP_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               phase_vld,
  input  logic [ADDR_W-1:0]  p_offs,
  input  logic [1:0]         wave_sel,
  output logic [ADDR_W-3:0]  rom_addr,
  input  logic [ADDR_W-3:0]  rom_data,
  output logic [AMP_W-1:0]   amp_out,
  output logic               amp_vld,
  output logic [1:0]         wave_cur
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    WAVE_SINE = 2'd0,
    WAVE_TRI  = 2'd1,
    WAVE_SAW  = 2'd2,
    WAVE_SQR  = 2'd3
  } wave_e;

  // S1 state
  logic [ADDR_W-1:0] a1_d, a1_q;
  logic              vld1_d, vld1_q;
  logic              prev_msb_d, prev_msb_q;
  logic              first_d, first_q;
  wave_e             wave_cur_d, wave_cur_q;
  // S2 state
  logic [ADDR_W-1:0] a2_d, a2_q;
  logic              vld2_d, vld2_q;
  wave_e             wave2_d, wave2_q;
  // S3 state
  logic [AMP_W-1:0]  amp_out_d, amp_out_q;
  logic              amp_vld_d, amp_vld_q;

  logic [AMP_W-1:0]  amp_res_s;
  logic              wrap_s;
  logic [IDX_W-1:0]  idx_s;

  // Only the top ADDR_W phase bits are used for lookup.
  logic unused_phase_bits;
  assign unused_phase_bits = ^phase_in[PHASE_W-ADDR_W-1:0];

  // S1 next state: phase truncation plus offset, wrap detect, waveform latch.
  always_comb begin
    a1_d       = a1_q;
    vld1_d     = 1'b0;
    prev_msb_d = prev_msb_q;
    first_d    = first_q;
    wave_cur_d = wave_cur_q;
    wrap_s     = 1'b0;
    if (phase_vld) begin
      // Carry out of the add is dropped: the offset wraps modulo 2**ADDR_W.
      a1_d       = phase_in[PHASE_W-1 -: ADDR_W] + p_offs;
      vld1_d     = 1'b1;
      prev_msb_d = phase_in[PHASE_W-1];
      wrap_s     = prev_msb_q & ~phase_in[PHASE_W-1];
      if (first_q || wrap_s) begin
        wave_cur_d = wave_e'(wave_sel);
        first_d    = 1'b0;
      end else begin
        wave_cur_d = wave_cur_q;
        first_d    = first_q;
      end
    end else begin
      a1_d   = a1_q;
      vld1_d = 1'b0;
    end
  end

  // Quarter-wave addressing: odd quadrants read the table backwards
  // (511 - idx is the bitwise complement for a 9-bit index).
  always_comb begin
    idx_s = a1_q[IDX_W-1:0];
    if (a1_q[IDX_W]) begin
      rom_addr = ~idx_s;
    end else begin
      rom_addr = idx_s;
    end
  end

  // S2 next state: S1 delayed one clock so it lines up with rom_data.
  // wave_cur_q only changes on an accepted sample, so it is exactly the
  // waveform of the sample sitting in S1.
  always_comb begin
    a2_d    = a1_q;
    vld2_d  = vld1_q;
    wave2_d = wave_cur_q;
  end

  // Amplitude from the S2 phase and the ROM magnitude.
  always_comb begin
    amp_res_s = {1'b1, {(AMP_W-1){1'b0}}};
    case (wave2_q)
      WAVE_SINE: begin
        // Upper half-cycle: 512 + mag; lower half-cycle: 511 - mag.
        if (a2_q[ADDR_W-1]) begin
          amp_res_s = {1'b0, ~rom_data};
        end else begin
          amp_res_s = {1'b1, rom_data};
        end
      end
      WAVE_TRI: begin
        if (a2_q[ADDR_W-1]) begin
          amp_res_s = ~a2_q[AMP_W-1:0];
        end else begin
          amp_res_s = a2_q[AMP_W-1:0];
        end
      end
      WAVE_SAW: begin
        amp_res_s = a2_q[ADDR_W-1:1];
      end
      WAVE_SQR: begin
        if (a2_q[ADDR_W-1]) begin
          amp_res_s = {AMP_W{1'b0}};
        end else begin
          amp_res_s = {AMP_W{1'b1}};
        end
      end
      default: begin
        amp_res_s = {1'b1, {(AMP_W-1){1'b0}}};
      end
    endcase
  end

  // S3 next state: load on a valid S2 sample, otherwise hold and drop valid.
  always_comb begin
    amp_out_d = amp_out_q;
    amp_vld_d = 1'b0;
    if (vld2_q) begin
      amp_out_d = amp_res_s;
      amp_vld_d = 1'b1;
    end else begin
      amp_out_d = amp_out_q;
      amp_vld_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards every in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q       <= {ADDR_W{1'b0}};
      vld1_q     <= 1'b0;
      prev_msb_q <= 1'b0;
      first_q    <= 1'b1;
      wave_cur_q <= WAVE_SINE;
      a2_q       <= {ADDR_W{1'b0}};
      vld2_q     <= 1'b0;
      wave2_q    <= WAVE_SINE;
      amp_out_q  <= {1'b1, {(AMP_W-1){1'b0}}};
      amp_vld_q  <= 1'b0;
    end else begin
      a1_q       <= a1_d;
      vld1_q     <= vld1_d;
      prev_msb_q <= prev_msb_d;
      first_q    <= first_d;
      wave_cur_q <= wave_cur_d;
      a2_q       <= a2_d;
      vld2_q     <= vld2_d;
      wave2_q    <= wave2_d;
      amp_out_q  <= amp_out_d;
      amp_vld_q  <= amp_vld_d;
    end
  end

  assign amp_out  = amp_out_q;
  assign amp_vld  = amp_vld_q;
  assign wave_cur = wave_cur_q;

endmodule
